axil_regbank: RTL
=================

# axil_regbank

AXI4-Lite peripheral-side register bank that terminates the bus driven by an AXI-Lite main. It holds NUM_REGS read/write registers with byte-strobe writes and exposes them in parallel to fabric logic. Each register write produces a one-cycle strobe. Out-of-range accesses complete with SLVERR.

## Interface
- DATA_WIDTH, 32, bus and register width in bits (32 or 64)
- ADDRESS_WIDTH, 32, byte-address width
- NUM_REGS, 16, number of registers (1..256)
- BASE_ADDR, 0, byte address of register 0; aligned to DATA_WIDTH/8
- clock  in  1  sole clock; all logic rising-edge
- reset  in  1  asynchronous, active-high reset
- awaddr  in  ADDRESS_WIDTH  write address
- awprot  in  3  ignored
- awvalid  in  1 / awready  out  1
- wdata  in  DATA_WIDTH / wstrb  in  DATA_WIDTH/8 / wvalid  in  1 / wready  out  1
- bresp  out  2 / bvalid  out  1 / bready  in  1
- araddr  in  ADDRESS_WIDTH / arprot  in  3 (ignored) / arvalid  in  1 / arready  out  1
- rdata  out  DATA_WIDTH / rresp  out  2 / rvalid  out  1 / rready  in  1
- reg_out  out  NUM_REGS*DATA_WIDTH  current register contents; register i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- wr_pulse  out  NUM_REGS  bit i high for one cycle when register i is written (any strobe pattern, including all-zero)

## Operation
- Decode: off = addr - BASE_ADDR; idx = off / (DATA_WIDTH/8); sub-word address bits are ignored. The access is in range only if addr >= BASE_ADDR and idx < NUM_REGS. Otherwise the response is SLVERR (2'b10). OKAY is 2'b00.
- ready_en flop: reset value 0; set on the first clock edge after reset deasserts.
- Write path, per-channel hold flags aw_held and w_held:
  - awready = ready_en & !aw_held & !bvalid
  - wready = ready_en & !w_held & !bvalid
  - An AW or W handshake without its partner latches the payload and sets the hold flag.
  - Commit happens on the edge where both payloads are available (held or handshaking this cycle).
  - At commit, each in-range byte lane with wstrb=1 is updated, wr_pulse[idx] is set, bvalid is set with bresp, and both hold flags clear.
  - An out-of-range commit writes nothing and produces no pulse.
  - bvalid stays high, with bresp stable, until bready is sampled high. Both readies stay low while bvalid is high.
- Read path:
  - arready = ready_en & !rvalid
  - On an AR handshake, rdata is captured from the register array as of that cycle and rvalid is set. Out-of-range reads return rdata=0 with SLVERR.
  - rdata and rresp hold stable until rready is sampled high.
- Read and write paths are fully independent and may handshake in the same cycle.

## Timing
- Reset, asynchronous, effective immediately:
  - All registers, reg_out, wr_pulse, bvalid, rvalid, rdata, bresp, rresp, hold flags and ready_en go to 0.
  - Therefore awready, wready and arready are 0 while reset is high and during the first cycle after release.
- Reset mid-transaction discards held AW/W payloads and any pending response. No write commits.
- Write with AW and W handshaking in cycle T:
  - Register, reg_out, wr_pulse and bvalid all change at T+1.
  - wr_pulse drops at T+2.
  - With bready=1 at T+1, bvalid is low and the readies are high at T+2. Sustained throughput is one write per 2 cycles.
- Write with AW at T and W at T+k: awready is low from T+1. Commit is on the edge ending T+k; response at T+k+1.
- Read with AR in cycle T: rvalid and rdata at T+1. With rready=1, the next AR is accepted at T+2.
- A write commit and an AR to the same register on the same edge: the read returns the pre-write value.
- Holding rready or bready low is an indefinite stall. Nothing is lost and outputs stay stable.

## Test plan
- Reset, then check outputs:
  - reset high: all readies and valids are 0 and reg_out is 0
  - cycle after release: readies still 0
  - next cycle: awready, wready and arready are 1
- Full write and readback, DATA_WIDTH=32, BASE_ADDR=0x100:
  - AW 0x108 and W 0xDEADBEEF with wstrb=4'hF in one cycle -> next cycle reg_out[2]=0xDEADBEEF, wr_pulse=0x0004 for one cycle, bresp=00
  - then read 0x108 -> rdata=0xDEADBEEF, rresp=00
- Partial strobe and split channels:
  - AW 0x104 at T, W 0x11223344 with wstrb=4'b0101 at T+3 -> awready low T+1..T+3, reg1 = 0x00220044, bvalid at T+4
- Out-of-range accesses:
  - write 0x140 with NUM_REGS=16 -> bresp=10, no reg_out change, wr_pulse=0
  - read 0x0FC -> rdata=0, rresp=10
- Backpressure:
  - bready=0 for 5 cycles -> bvalid and bresp stable, awready/wready=0 throughout, no second commit
  - same with rready=0 -> rdata stable
- Collision and mid-reset:
  - write 0xA5A5A5A5 to reg0 committing on the same edge as AR of reg0 -> rdata = old value 0
  - assert reset with an AW held -> bvalid never rises, reg_out stays 0

Source files
------------

// File: rtl/axil_regbank.sv
// axil_regbank: AXI4-Lite peripheral-side register bank.
// NUM_REGS read/write registers with byte-strobe writes, exposed in parallel
// on reg_out, with a one-cycle wr_pulse per committed register write.
// Accesses outside the register window complete with SLVERR.
module axil_regbank #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int NUM_REGS      = 16,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [ADDRESS_WIDTH-1:0]       awaddr,
  input  logic [2:0]                     awprot,
  input  logic                           awvalid,
  output logic                           awready,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [DATA_WIDTH/8-1:0]        wstrb,
  input  logic                           wvalid,
  output logic                           wready,
  output logic [1:0]                     bresp,
  output logic                           bvalid,
  input  logic                           bready,
  input  logic [ADDRESS_WIDTH-1:0]       araddr,
  input  logic [2:0]                     arprot,
  input  logic                           arvalid,
  output logic                           arready,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic [1:0]                     rresp,
  output logic                           rvalid,
  input  logic                           rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  output logic [NUM_REGS-1:0]            wr_pulse
);

  localparam int STRB_W   = DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Word index relative to the base; sub-word address bits drop out here.
  function automatic logic [ADDRESS_WIDTH-1:0] word_index(input logic [ADDRESS_WIDTH-1:0] addr);
    word_index = (addr - BASE_ADDR) >> ADDR_LSB;
  endfunction

  // In range only when at/above the base and the word index hits a register.
  function automatic logic addr_ok(input logic [ADDRESS_WIDTH-1:0] addr);
    addr_ok = (addr >= BASE_ADDR) && (word_index(addr) < ADDRESS_WIDTH'(NUM_REGS));
  endfunction

  logic [DATA_WIDTH-1:0]    regs_r [NUM_REGS];
  logic                     ready_en_r;
  logic                     aw_held_r;
  logic [ADDRESS_WIDTH-1:0] aw_addr_r;
  logic                     w_held_r;
  logic [DATA_WIDTH-1:0]    w_data_r;
  logic [STRB_W-1:0]        w_strb_r;
  logic                     bvalid_r;
  logic [1:0]               bresp_r;
  logic                     rvalid_r;
  logic [1:0]               rresp_r;
  logic [DATA_WIDTH-1:0]    rdata_r;
  logic [NUM_REGS-1:0]      wr_pulse_r;

  logic                     aw_hs_s;
  logic                     w_hs_s;
  logic                     ar_hs_s;
  logic                     commit_s;
  logic [ADDRESS_WIDTH-1:0] cm_addr_s;
  logic [DATA_WIDTH-1:0]    cm_data_s;
  logic [STRB_W-1:0]        cm_strb_s;
  logic [ADDRESS_WIDTH-1:0] cm_word_s;
  logic [IDX_W-1:0]         cm_idx_s;
  logic                     cm_ok_s;
  logic [ADDRESS_WIDTH-1:0] ar_word_s;
  logic [IDX_W-1:0]         ar_idx_s;
  logic                     ar_ok_s;
  logic                     unused_prot_s;

  // Protection bits carry no meaning for this peripheral.
  assign unused_prot_s = ^{awprot, arprot};

  assign awready = ready_en_r & ~aw_held_r & ~bvalid_r;
  assign wready  = ready_en_r & ~w_held_r  & ~bvalid_r;
  assign arready = ready_en_r & ~rvalid_r;

  assign aw_hs_s = awvalid & awready;
  assign w_hs_s  = wvalid  & wready;
  assign ar_hs_s = arvalid & arready;

  // Commit once both halves of a write are present, held or arriving now.
  assign commit_s = (aw_held_r | aw_hs_s) & (w_held_r | w_hs_s);

  // Select the write payload (held copy wins) and decode both addresses.
  always_comb begin
    cm_addr_s = awaddr;
    cm_data_s = wdata;
    cm_strb_s = wstrb;
    if (aw_held_r) begin
      cm_addr_s = aw_addr_r;
    end else begin
      cm_addr_s = awaddr;
    end
    if (w_held_r) begin
      cm_data_s = w_data_r;
      cm_strb_s = w_strb_r;
    end else begin
      cm_data_s = wdata;
      cm_strb_s = wstrb;
    end
    cm_word_s = word_index(cm_addr_s);
    cm_idx_s  = cm_word_s[IDX_W-1:0];
    cm_ok_s   = addr_ok(cm_addr_s);
    ar_word_s = word_index(araddr);
    ar_idx_s  = ar_word_s[IDX_W-1:0];
    ar_ok_s   = addr_ok(araddr);
  end

  // Readies open one edge after reset is released.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ready_en_r <= 1'b0;
    end else begin
      ready_en_r <= 1'b1;
    end
  end

  // Hold an AW or W payload that arrives ahead of its partner.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      aw_held_r <= 1'b0;
      aw_addr_r <= '0;
      w_held_r  <= 1'b0;
      w_data_r  <= '0;
      w_strb_r  <= '0;
    end else if (commit_s) begin
      aw_held_r <= 1'b0;
      w_held_r  <= 1'b0;
    end else begin
      if (aw_hs_s) begin
        aw_held_r <= 1'b1;
        aw_addr_r <= awaddr;
      end
      if (w_hs_s) begin
        w_held_r <= 1'b1;
        w_data_r <= wdata;
        w_strb_r <= wstrb;
      end
    end
  end

  // Write response: raised at commit, held until bready is sampled.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bvalid_r <= 1'b0;
      bresp_r  <= RESP_OKAY;
    end else if (commit_s) begin
      bvalid_r <= 1'b1;
      bresp_r  <= cm_ok_s ? RESP_OKAY : RESP_SLVERR;
    end else if (bvalid_r && bready) begin
      bvalid_r <= 1'b0;
    end
  end

  // Register array update with byte strobes, plus the one-cycle write pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= '0;
      end
      wr_pulse_r <= '0;
    end else begin
      wr_pulse_r <= '0;
      if (commit_s && cm_ok_s) begin
        wr_pulse_r[cm_idx_s] <= 1'b1;
        for (int b = 0; b < STRB_W; b++) begin
          if (cm_strb_s[b]) begin
            regs_r[cm_idx_s][b*8 +: 8] <= cm_data_s[b*8 +: 8];
          end
        end
      end
    end
  end

  // Read channel: capture pre-write register contents on AR, hold until rready.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rvalid_r <= 1'b0;
      rresp_r  <= RESP_OKAY;
      rdata_r  <= '0;
    end else if (ar_hs_s) begin
      rvalid_r <= 1'b1;
      rresp_r  <= ar_ok_s ? RESP_OKAY : RESP_SLVERR;
      rdata_r  <= ar_ok_s ? regs_r[ar_idx_s] : '0;
    end else if (rvalid_r && rready) begin
      rvalid_r <= 1'b0;
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_REGS; g++) begin : g_reg_out
      assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = regs_r[g];
    end
  endgenerate

  assign bvalid   = bvalid_r;
  assign bresp    = bresp_r;
  assign rvalid   = rvalid_r;
  assign rresp    = rresp_r;
  assign rdata    = rdata_r;
  assign wr_pulse = wr_pulse_r;

endmodule
